// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding, frame sizing.
// Optional feature macro: UART_TX_BREAK_EN adds the BREAK state.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef UART_TX_BREAK_EN
    , ST_BREAK
`endif
  } tx_state_t;

  // Serial bits in one frame: start + data + parity + stop
  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned p,
                                             input int unsigned s);
    return 1 + data_w + p + s;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate counter: counts 0..CLKS_PER_BIT-1 while enabled, tick marks the last count.
// tick is registered; it is high exactly while the count equals CLKS_PER_BIT-1.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  // Wrap at LAST; tick is predicted one cycle early so it lines up with cnt == LAST
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == PRE);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready intake, runtime parity and stop-bit count.
// Optional feature macro: UART_TX_BREAK_EN adds input tx_break and a line-break state.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic              tx_break,
`endif
  output logic              tx_ready,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              tx,
  output logic              tx_busy,
  output logic              frame_done
);

  // Bit counter covers data index, stop index and break length (up to DATA_W+2)
  localparam int unsigned BIT_W = $clog2(frame_bits(DATA_W, 1, 2));
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [BIT_W-1:0] LAST_BRK  = BIT_W'(DATA_W + 2);
`endif

  if (CNT_W != $clog2(CLKS_PER_BIT) || DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2)
  begin : g_bad_param
    $error("uart_tx_param: illegal parameter set");
  end

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bitn;
  logic              par_en;
  logic              par_bit;
  logic              stop2;
  logic              ready_q;
  logic              tick;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state == ST_IDLE),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  // Ready is withheld during the reset cycle itself
  assign tx_ready = ready_q & ~rst;

  // Frame sequencer; every output except the rst gating of tx_ready is registered
  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bitn    <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      stop2   <= 1'b0;
      ready_q <= 1'b1;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (tx_break) begin
            state   <= ST_BREAK;
            bitn    <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            ready_q <= 1'b0;
          end else
`endif
          if (tx_valid) begin
            state   <= ST_START;
            shreg   <= tx_data;
            par_en  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            par_bit <= (cfg_parity == PAR_ODD) ? ~(^tx_data) : ^tx_data;
            stop2   <= cfg_stop2;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            bitn  <= '0;
            tx    <= shreg[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bitn == LAST_DATA) begin
              bitn <= '0;
              if (par_en) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bitn  <= bitn + BIT_W'(1);
              shreg <= shreg >> 1;
              tx    <= shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            bitn  <= '0;
            tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop2 && (bitn == '0)) begin
              bitn <= BIT_W'(1);
            end else begin
              state      <= ST_IDLE;
              bitn       <= '0;
              frame_done <= 1'b1;
              tx_busy    <= 1'b0;
              ready_q    <= 1'b1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        ST_BREAK: begin
          if (tick) begin
            if (bitn == LAST_BRK) begin
              state   <= ST_IDLE;
              bitn    <= '0;
              tx      <= 1'b1;
              tx_busy <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              bitn <= bitn + BIT_W'(1);
            end
          end
        end
`endif
        default: begin
          state   <= ST_IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param: directed and random frames against a bit-list frame model.
// Optional feature macro: UART_TX_BREAK_EN exercises the break state.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_break;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       sel5;

  logic tx8, rdy8, busy8, done8;
  logic tx5, rdy5, busy5, done5;
  logic v8, v5, b8, b5;
  logic obs_tx, obs_ready, obs_busy, obs_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign v8 = tx_valid & ~sel5;
  assign v5 = tx_valid & sel5;
  assign b8 = tx_break & ~sel5;
  assign b5 = tx_break & sel5;
  assign obs_tx    = sel5 ? tx5   : tx8;
  assign obs_ready = sel5 ? rdy5  : rdy8;
  assign obs_busy  = sel5 ? busy5 : busy8;
  assign obs_done  = sel5 ? done5 : done8;

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut8 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v8),
`ifdef UART_TX_BREAK_EN
    .tx_break(b8),
`endif
    .tx_ready(rdy8), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx(tx8), .tx_busy(busy8), .frame_done(done8)
  );

  uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(CPB)) dut5 (
    .clk(clk), .rst(rst), .tx_data(tx_data[4:0]), .tx_valid(v5),
`ifdef UART_TX_BREAK_EN
    .tx_break(b5),
`endif
    .tx_ready(rdy5), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx(tx5), .tx_busy(busy5), .frame_done(done5)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of line levels, one per bit period
  function automatic int frame_model(input logic [7:0] d, input int w, input logic [1:0] par,
                                     input logic s2, output logic [15:0] bits);
    int   n;
    logic p;
    bits = '1;
    n = 0;
    p = 1'b0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < w; i++) begin
      bits[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (par == 2'b01) begin bits[n] = p;  n++; end
    else if (par == 2'b10) begin bits[n] = ~p; n++; end
    bits[n] = 1'b1; n++;
    if (s2) begin bits[n] = 1'b1; n++; end
    return n;
  endfunction

  // Offer one payload and check every cycle of its frame; optional reset abort at window abort_at
  task automatic run_frame(input logic [7:0] d, input logic [1:0] par, input logic s2,
                           input bit hold, input int abort_at);
    logic [15:0] bits;
    int nb, len, guard;
    nb  = frame_model(d, sel5 ? 5 : 8, par, s2, bits);
    len = nb * CPB;
    tx_data = d; cfg_parity = par; cfg_stop2 = s2; tx_valid = 1'b1;
    guard = 0;
    while (!obs_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait", 16'(guard < 200), 16'd1);
    for (int j = 0; j <= len; j++) begin
      @(negedge clk);
      if (j == 0 && !hold) tx_valid = 1'b0;
      if (j == 2) begin
        cfg_parity = 2'($urandom);
        cfg_stop2  = 1'($urandom);
        if (!hold) tx_data = 8'($urandom);
      end
      if (j == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_tx", 16'(obs_tx), 16'd1);
        chk("abort_ready", 16'(obs_ready), 16'd1);
        chk("abort_busy", 16'(obs_busy), 16'd0);
        chk("abort_done", 16'(obs_done), 16'd0);
        return;
      end
      if (j < len) begin
        chk("tx_bit", 16'(obs_tx), 16'(bits[j / CPB]));
        chk("busy", 16'(obs_busy), 16'd1);
        chk("ready_low", 16'(obs_ready), 16'd0);
        chk("done_low", 16'(obs_done), 16'd0);
      end else begin
        chk("idle_tx", 16'(obs_tx), 16'd1);
        chk("idle_ready", 16'(obs_ready), 16'd1);
        chk("idle_busy", 16'(obs_busy), 16'd0);
        chk("frame_done", 16'(obs_done), 16'd1);
      end
    end
  endtask

  // Run n random frames, randomly back-to-back, ending with valid dropped
  task automatic random_frames(input int n);
    for (int i = 0; i < n; i++)
      run_frame(8'($urandom), 2'($urandom), 1'($urandom), (i != n - 1) && 1'($urandom), -1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_break = 1'b0; tx_data = '0;
    cfg_parity = 2'b00; cfg_stop2 = 1'b0; sel5 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready_gated", 16'(obs_ready), 16'd0);
    rst = 1'b0;
    #1;
    chk("rst_tx", 16'(obs_tx), 16'd1);
    chk("rst_ready", 16'(obs_ready), 16'd1);
    chk("rst_busy", 16'(obs_busy), 16'd0);
    chk("rst_done", 16'(obs_done), 16'd0);

    run_frame(8'hA5, 2'b01, 1'b0, 1'b0, -1);
    run_frame(8'h01, 2'b10, 1'b1, 1'b0, -1);
    run_frame(8'h01, 2'b01, 1'b1, 1'b0, -1);
    run_frame(8'hFF, 2'b00, 1'b0, 1'b0, -1);
    run_frame(8'hFF, 2'b11, 1'b0, 1'b0, -1);
    run_frame(8'h3C, 2'b01, 1'b0, 1'b1, -1);
    run_frame(8'hC3, 2'b10, 1'b0, 1'b0, -1);
    run_frame(8'h5A, 2'b01, 1'b0, 1'b0, 17);
    run_frame(8'h96, 2'b10, 1'b1, 1'b0, -1);
    random_frames(16);

    sel5 = 1'b1;
    @(negedge clk);
    run_frame(8'h15, 2'b00, 1'b0, 1'b0, -1);
`ifdef UART_TX_BREAK_EN
    tx_break = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h0A;
    for (int j = 0; j <= (5 + 3) * CPB; j++) begin
      @(negedge clk);
      if (j == 0) begin tx_break = 1'b0; tx_valid = 1'b0; end
      if (j < (5 + 3) * CPB) begin
        chk("brk_tx", 16'(obs_tx), 16'd0);
        chk("brk_ready", 16'(obs_ready), 16'd0);
        chk("brk_busy", 16'(obs_busy), 16'd1);
        chk("brk_done", 16'(obs_done), 16'd0);
      end else begin
        chk("brk_end_tx", 16'(obs_tx), 16'd1);
        chk("brk_end_ready", 16'(obs_ready), 16'd1);
        chk("brk_end_busy", 16'(obs_busy), 16'd0);
        chk("brk_end_done", 16'(obs_done), 16'd0);
      end
    end
`endif
    random_frames(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
